// File: rtl/fifo_datapath.sv
// Four-entry FIFO datapath with lap-bit wrap pointers, a registered read port
// with write-first bypass, and sticky overflow/underflow flags.
module fifo_datapath #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             writeEn,
  input  logic             inc_write_ctr,
  input  logic             readEn,
  input  logic             inc_read_ctr,
  output logic [2:0]       read_ctr,
  output logic [2:0]       write_ctr,
  output logic [WIDTH-1:0] data_out,
  output logic [2:0]       occupancy,
  output logic             overflow_err,
  output logic             underflow_err
);

  logic [WIDTH-1:0] mem_reg [4];
  logic [2:0]       read_ctr_reg, read_ctr_next;
  logic [2:0]       write_ctr_reg, write_ctr_next;
  logic [WIDTH-1:0] data_out_reg, data_out_next;
  logic             overflow_reg, overflow_next;
  logic             underflow_reg, underflow_next;
  logic             full, empty, bypass;

  // Full/empty come from the pre-edge pointers so error checks see the old state.
  assign full   = (write_ctr_reg[2] != read_ctr_reg[2]) &&
                  (write_ctr_reg[1:0] == read_ctr_reg[1:0]);
  assign empty  = (write_ctr_reg == read_ctr_reg);
  assign bypass = writeEn && (write_ctr_reg[1:0] == read_ctr_reg[1:0]);

  always_comb begin
    write_ctr_next = write_ctr_reg;
    read_ctr_next  = read_ctr_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;
    data_out_next  = data_out_reg;
    if (inc_write_ctr) begin
      if (full) overflow_next = 1'b1;
      else      write_ctr_next = write_ctr_reg + 3'd1;
    end
    if (inc_read_ctr) begin
      if (empty) underflow_next = 1'b1;
      else       read_ctr_next = read_ctr_reg + 3'd1;
    end
    if (readEn) begin
      if (bypass) data_out_next = data_in;
      else        data_out_next = mem_reg[read_ctr_reg[1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      read_ctr_reg  <= 3'd0;
      write_ctr_reg <= 3'd0;
      data_out_reg  <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      read_ctr_reg  <= read_ctr_next;
      write_ctr_reg <= write_ctr_next;
      data_out_reg  <= data_out_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  // Storage keeps its contents through reset; only the reset edge's write is dropped.
  always_ff @(posedge clk) begin
    if (!rst && writeEn) begin
      mem_reg[write_ctr_reg[1:0]] <= data_in;
    end
  end

  assign read_ctr      = read_ctr_reg;
  assign write_ctr     = write_ctr_reg;
  assign data_out      = data_out_reg;
  assign occupancy     = write_ctr_reg - read_ctr_reg;
  assign overflow_err  = overflow_reg;
  assign underflow_err = underflow_reg;

endmodule

// File: tb/tb_fifo_datapath.sv
// Self-checking bench for fifo_datapath: directed scenarios plus a randomized
// run compared against a queue-based reference model.
module tb_fifo_datapath;

  localparam int WIDTH = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] data_in;
  logic             writeEn, inc_write_ctr, readEn, inc_read_ctr;
  logic [2:0]       read_ctr, write_ctr, occupancy;
  logic [WIDTH-1:0] data_out;
  logic             overflow_err, underflow_err;

  int errors = 0;
  int checks = 0;

  // Reference model: queue contents plus free-running pointer counts.
  logic [WIDTH-1:0] q[$];
  int               exp_w, exp_r;
  logic [WIDTH-1:0] exp_dout;

  fifo_datapath #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .writeEn(writeEn),
    .inc_write_ctr(inc_write_ctr), .readEn(readEn), .inc_read_ctr(inc_read_ctr),
    .read_ctr(read_ctr), .write_ctr(write_ctr), .data_out(data_out),
    .occupancy(occupancy), .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; writeEn = 0; inc_write_ctr = 0; readEn = 0; inc_read_ctr = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); rst = 0;
    q.delete(); exp_w = 0; exp_r = 0; exp_dout = '0;
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    idle(); data_in = d; writeEn = 1; inc_write_ctr = 1; tick(); idle();
    q.push_back(d); exp_w = (exp_w + 1) % 8;
  endtask

  task automatic pop_check(input string name);
    idle(); readEn = 1; inc_read_ctr = 1; tick(); idle();
    exp_dout = q.pop_front(); exp_r = (exp_r + 1) % 8;
    checks++;
    if (data_out !== exp_dout) begin
      errors++;
      $display("FAIL %s data_out got=%h exp=%h", name, data_out, exp_dout);
    end
  endtask

  task automatic test_reset();
    data_in = '0;
    do_reset();
    checks++;
    if ({read_ctr, write_ctr, occupancy} !== 9'd0) begin
      errors++;
      $display("FAIL reset ptrs rd=%0d wr=%0d occ=%0d exp 0/0/0", read_ctr, write_ctr, occupancy);
    end
    checks++;
    if ({overflow_err, underflow_err} !== 2'b00 || data_out !== '0) begin
      errors++;
      $display("FAIL reset flags ovf=%b unf=%b dout=%h exp 0/0/0", overflow_err, underflow_err, data_out);
    end
    $display("reset: rd=%0d wr=%0d occ=%0d", read_ctr, write_ctr, occupancy);
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 4; i++) begin
      idle(); data_in = 64'hA1 + 64'(i); writeEn = 1; tick();
      idle(); inc_write_ctr = 1; tick(); idle();
      q.push_back(64'hA1 + 64'(i)); exp_w = (exp_w + 1) % 8;
      $display("fill: wrote %h wr=%0d occ=%0d", 64'hA1 + 64'(i), write_ctr, occupancy);
    end
    checks++;
    if (write_ctr !== 3'd4 || occupancy !== 3'd4 || read_ctr !== 3'd0 ||
        overflow_err !== 1'b0 || underflow_err !== 1'b0) begin
      errors++;
      $display("FAIL fill_state wr=%0d occ=%0d rd=%0d ovf=%b unf=%b exp 4/4/0/0/0",
               write_ctr, occupancy, read_ctr, overflow_err, underflow_err);
    end
    for (int i = 0; i < 4; i++) begin
      idle(); readEn = 1; tick(); idle();
      exp_dout = q.pop_front();
      checks++;
      if (data_out !== exp_dout) begin
        errors++;
        $display("FAIL drain_data[%0d] got=%h exp=%h", i, data_out, exp_dout);
      end
      inc_read_ctr = 1; tick(); idle(); exp_r = (exp_r + 1) % 8;
      $display("drain: read %h rd=%0d occ=%0d", data_out, read_ctr, occupancy);
    end
    checks++;
    if (read_ctr !== 3'd4 || occupancy !== 3'd0) begin
      errors++;
      $display("FAIL drain_state rd=%0d occ=%0d exp 4/0", read_ctr, occupancy);
    end
  endtask

  task automatic test_wrap();
    // Starts at pointers 4/4, so 12 commits wrap each pointer past 7 twice.
    for (int i = 0; i < 12; i++) begin
      push({$urandom, $urandom});
      if (i % 3 == 0 && i < 11) begin
        push({$urandom, $urandom});
        pop_check("wrap_extra");
      end
      pop_check("wrap");
      checks++;
      if (write_ctr !== 3'(exp_w) || read_ctr !== 3'(exp_r) || occupancy !== 3'(q.size()) ||
          occupancy > 3'd4 || overflow_err !== 1'b0 || underflow_err !== 1'b0) begin
        errors++;
        $display("FAIL wrap_state wr=%0d rd=%0d occ=%0d ovf=%b unf=%b exp %0d/%0d/%0d/0/0",
                 write_ctr, read_ctr, occupancy, overflow_err, underflow_err, exp_w, exp_r, q.size());
      end
      $display("wrap %0d: wr=%0d rd=%0d occ=%0d dout=%h", i, write_ctr, read_ctr, occupancy, data_out);
    end
  endtask

  task automatic test_random();
    logic             do_w, do_r;
    logic [WIDTH-1:0] d;
    for (int n = 0; n < 200; n++) begin
      idle();
      do_w = ($urandom_range(0, 1) == 1) && (q.size() < 4);
      do_r = ($urandom_range(0, 1) == 1) && (q.size() > 0);
      d = {$urandom, $urandom};
      data_in = d; writeEn = do_w; inc_write_ctr = do_w; readEn = do_r; inc_read_ctr = do_r;
      tick(); idle();
      if (do_r) begin exp_dout = q.pop_front(); exp_r = (exp_r + 1) % 8; end
      if (do_w) begin q.push_back(d); exp_w = (exp_w + 1) % 8; end
      checks++;
      if (data_out !== exp_dout || write_ctr !== 3'(exp_w) || read_ctr !== 3'(exp_r) ||
          occupancy !== 3'(q.size()) || overflow_err !== 1'b0 || underflow_err !== 1'b0) begin
        errors++;
        $display("FAIL random[%0d] dout=%h wr=%0d rd=%0d occ=%0d ovf=%b unf=%b exp %h/%0d/%0d/%0d/0/0",
                 n, data_out, write_ctr, read_ctr, occupancy, overflow_err, underflow_err,
                 exp_dout, exp_w, exp_r, q.size());
      end
      $display("random %0d: w=%b r=%b wr=%0d rd=%0d occ=%0d", n, do_w, do_r, write_ctr, read_ctr, occupancy);
    end
  endtask

  task automatic test_errors();
    do_reset();
    for (int i = 0; i < 4; i++) push(64'hC0 + 64'(i));
    idle(); inc_write_ctr = 1; tick(); idle();
    checks++;
    if (overflow_err !== 1'b1 || write_ctr !== 3'd4 || occupancy !== 3'd4 || underflow_err !== 1'b0) begin
      errors++;
      $display("FAIL overflow ovf=%b wr=%0d occ=%0d unf=%b exp 1/4/4/0", overflow_err, write_ctr, occupancy, underflow_err);
    end
    $display("overflow: ovf=%b wr=%0d", overflow_err, write_ctr);
    // Full with both increments: write is refused, read still advances.
    idle(); inc_write_ctr = 1; inc_read_ctr = 1; tick(); idle();
    void'(q.pop_front()); exp_r = 1;
    checks++;
    if (write_ctr !== 3'd4 || read_ctr !== 3'd1 || occupancy !== 3'd3) begin
      errors++;
      $display("FAIL full_both wr=%0d rd=%0d occ=%0d exp 4/1/3", write_ctr, read_ctr, occupancy);
    end
    for (int i = 0; i < 3; i++) pop_check("err_drain");
    idle(); inc_read_ctr = 1; tick(); idle();
    checks++;
    if (underflow_err !== 1'b1 || read_ctr !== 3'd4 || occupancy !== 3'd0) begin
      errors++;
      $display("FAIL underflow unf=%b rd=%0d occ=%0d exp 1/4/0", underflow_err, read_ctr, occupancy);
    end
    $display("underflow: unf=%b rd=%0d", underflow_err, read_ctr);
    // Empty with both increments: read is refused, write still advances.
    idle(); data_in = 64'hD0; writeEn = 1; inc_write_ctr = 1; inc_read_ctr = 1; tick(); idle();
    checks++;
    if (write_ctr !== 3'd5 || read_ctr !== 3'd4 || occupancy !== 3'd1) begin
      errors++;
      $display("FAIL empty_both wr=%0d rd=%0d occ=%0d exp 5/4/1", write_ctr, read_ctr, occupancy);
    end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (overflow_err !== 1'b1 || underflow_err !== 1'b1) begin
      errors++;
      $display("FAIL sticky ovf=%b unf=%b exp 1/1", overflow_err, underflow_err);
    end
    do_reset();
    checks++;
    if (overflow_err !== 1'b0 || underflow_err !== 1'b0) begin
      errors++;
      $display("FAIL flag_clear ovf=%b unf=%b exp 0/0", overflow_err, underflow_err);
    end
    $display("errors cleared: ovf=%b unf=%b", overflow_err, underflow_err);
  endtask

  task automatic test_bypass();
    do_reset();
    idle(); data_in = 64'h5A; writeEn = 1; readEn = 1; tick(); idle();
    checks++;
    if (data_out !== 64'h5A || occupancy !== 3'd0) begin
      errors++;
      $display("FAIL bypass dout=%h occ=%0d exp 5a/0", data_out, occupancy);
    end
    data_in = 64'h77; tick();
    checks++;
    if (data_out !== 64'h5A) begin
      errors++;
      $display("FAIL hold dout=%h exp 5a", data_out);
    end
    $display("bypass: dout=%h", data_out);
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) push(64'h10 + 64'(i));
    idle(); inc_read_ctr = 1; tick(); idle();
    checks++;
    if (occupancy !== 3'd3) begin
      errors++;
      $display("FAIL pre_reset occ=%0d exp 3", occupancy);
    end
    // write_ctr now indexes entry 0; the write in the reset edge must not land.
    idle(); rst = 1; inc_write_ctr = 1; writeEn = 1; data_in = 64'hEE; tick(); idle();
    checks++;
    if ({read_ctr, write_ctr, occupancy} !== 9'd0 || data_out !== '0 ||
        overflow_err !== 1'b0 || underflow_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset rd=%0d wr=%0d occ=%0d dout=%h ovf=%b unf=%b exp all 0",
               read_ctr, write_ctr, occupancy, data_out, overflow_err, underflow_err);
    end
    idle(); readEn = 1; tick(); idle();
    checks++;
    if (data_out !== 64'h10) begin
      errors++;
      $display("FAIL reset_write_ignored dout=%h exp 10", data_out);
    end
    $display("mid reset: occ=%0d mem0=%h", occupancy, data_out);
    do_reset();
  endtask

  initial begin
    idle();
    data_in = '0;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_random();
    test_errors();
    test_bypass();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
